// File: rtl/furv_pkg.sv
// furv_pkg: shared definitions for the furv data-memory responder.
//   state_e      - responder FSM states (IDLE / WAIT / RESP)
//   decode_t     - word index plus combined alignment/range error flag
//   decode_addr  - maps a byte address onto the word array and flags
//                  misaligned or out-of-range accesses
package furv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] index;
  } decode_t;

  // Index is computed from the wrapped offset; any address below the base
  // is rejected explicitly, so the wrapped value never reaches the array.
  function automatic decode_t decode_addr(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] depth);
    decode_t     d;
    logic [31:0] off;
    off     = addr - base;
    d.index = off >> 2;
    d.err   = (addr[1:0] != 2'b00) || (addr < base) || (d.index >= depth);
    return d;
  endfunction

endpackage

// File: rtl/furv_sram.sv
// furv_sram: DEPTH_WORDS x 32 single-port word array.
//   clk    - clock, all activity on the rising edge
//   we     - write enable; wdata is stored at addr
//   re     - read enable; mem[addr] is captured into the read register
//   addr   - word address shared by read and write
//   wdata  - write data
//   rdata  - registered read data, held until the next read
// The array has no reset: contents survive a reset of the surrounding logic.
module furv_sram
  import furv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/furv_dmem.sv
// furv_dmem: data-memory responder for the core load/store port.
//   clk      - clock
//   rst_n    - asynchronous active-low reset (array contents are kept)
//   mem_req  - request strobe, accepted only while idle
//   mem_read - 1 = load, 0 = store
//   addr     - byte address (whole words only)
//   wdata    - store data
//   rdata    - load data, updated in the response cycle of a load
//   busy     - request in flight; new requests are ignored
//   rvalid   - one-cycle response pulse, LATENCY edges after accept
//   err      - misaligned / out-of-range flag, qualified by rvalid
module furv_dmem
  import furv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        rvalid,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic        err_pend_q, err_pend_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;

  decode_t     dec;
  logic        accept;
  logic [31:0] sram_rdata;
  logic        unused_idx_bits;

  assign dec    = decode_addr(addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign accept = (state_q == ST_IDLE) && mem_req;

  // Upper index bits only matter through dec.err.
  assign unused_idx_bits = ^dec.index[31:AW];

  // Store commits and load read launches both happen on the accept edge;
  // erroneous accesses never touch the array.
  furv_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk  (clk),
    .we   (accept && !mem_read && !dec.err),
    .re   (accept && mem_read && !dec.err),
    .addr (dec.index[AW-1:0]),
    .wdata(wdata),
    .rdata(sram_rdata)
  );

  // The read register of the array is stable from the accept edge until the
  // next accept, so the response cycle can present it directly; this also
  // covers LATENCY==1 where there is no spare edge to re-register it.
  // Outside a load response the last presented value is held in rdata_q.
  assign rdata = (rvalid_q && rd_q) ? (err_pend_q ? 32'h0 : sram_rdata) : rdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    err_pend_d = err_pend_q;
    rdata_d    = rdata;

    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          rd_d       = mem_read;
          err_pend_d = dec.err;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d   = (state_d != ST_IDLE);
    rvalid_d = (state_d == ST_RESP);
    err_d    = rvalid_d && err_pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      rd_q       <= 1'b0;
      err_pend_q <= 1'b0;
      rdata_q    <= 32'h0;
      busy_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      err_pend_q <= err_pend_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
    end
  end

  assign busy   = busy_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_furv_dmem.sv
// tb_furv_dmem: four responder instances (different latency / base address)
// driven one at a time, checked every cycle against a request-level model
// and by literal expectations for the directed scenarios.
module tb_furv_dmem;

  localparam int NL    = 4;
  localparam int DEPTH = 1024;
  localparam int          LAT_T  [NL] = '{4, 2, 1, 3};
  localparam logic [31:0] BASE_T [NL] = '{32'h0, 32'h0, 32'h0, 32'h0001_0000};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        req     [NL];
  logic        rd_i    [NL];
  logic [31:0] addr_i  [NL];
  logic [31:0] wdata_i [NL];
  logic [31:0] rdata_o [NL];
  logic        busy_o  [NL];
  logic        rvalid_o[NL];
  logic        err_o   [NL];

  int total = 0;
  int bad   = 0;
  bit done  = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NL; gi++) begin : g_dut
    furv_dmem #(
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (BASE_T[gi]),
      .LATENCY    (LAT_T[gi])
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mem_req (req[gi]),
      .mem_read(rd_i[gi]),
      .addr    (addr_i[gi]),
      .wdata   (wdata_i[gi]),
      .rdata   (rdata_o[gi]),
      .busy    (busy_o[gi]),
      .rvalid  (rvalid_o[gi]),
      .err     (err_o[gi])
    );
  end

  // ---------------- request-level model ----------------
  // m_rem = cycles of busy left; the response cycle is the one with m_rem==1.
  logic [31:0] m_mem   [NL][DEPTH];
  int          m_rem   [NL];
  bit          m_rd    [NL];
  bit          m_err   [NL];
  logic [31:0] m_ldata [NL];
  logic [31:0] m_rdata [NL];

  function automatic bit addr_bad(int ln, logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE_T[ln]) ||
           ((a - BASE_T[ln]) >= 32'(DEPTH * 4));
  endfunction

  function automatic int widx(int ln, logic [31:0] a);
    return int'(((a - BASE_T[ln]) >> 2) & 32'(DEPTH - 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int ln = 0; ln < NL; ln++) begin
      if (!rst_n) begin
        m_rem[ln]   <= 0;
        m_rd[ln]    <= 1'b0;
        m_err[ln]   <= 1'b0;
        m_rdata[ln] <= 32'h0;
      end else if (m_rem[ln] == 0) begin
        if (req[ln]) begin
          m_rem[ln]   <= LAT_T[ln];
          m_rd[ln]    <= rd_i[ln];
          m_err[ln]   <= addr_bad(ln, addr_i[ln]);
          m_ldata[ln] <= addr_bad(ln, addr_i[ln]) ? 32'h0 : m_mem[ln][widx(ln, addr_i[ln])];
          if (!rd_i[ln] && !addr_bad(ln, addr_i[ln]))
            m_mem[ln][widx(ln, addr_i[ln])] <= wdata_i[ln];
          if (LAT_T[ln] == 1 && rd_i[ln])
            m_rdata[ln] <= addr_bad(ln, addr_i[ln]) ? 32'h0 : m_mem[ln][widx(ln, addr_i[ln])];
        end
      end else begin
        m_rem[ln] <= m_rem[ln] - 1;
        if (m_rem[ln] == 2 && m_rd[ln])
          m_rdata[ln] <= m_ldata[ln];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_access(input int ln, input bit rd, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] r_o,
                           output bit e_o, output int edges, output int bcnt);
    @(negedge clk);
    req[ln] = 1'b1; rd_i[ln] = rd; addr_i[ln] = a; wdata_i[ln] = wd;
    @(negedge clk);
    // Request side scrambled while busy; must have no effect.
    req[ln] = 1'b0; rd_i[ln] = 1'($urandom); addr_i[ln] = $urandom; wdata_i[ln] = $urandom;
    edges = 1;
    bcnt  = (busy_o[ln] === 1'b1) ? 1 : 0;
    while (rvalid_o[ln] !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
      if (busy_o[ln] === 1'b1) bcnt++;
    end
    if (rvalid_o[ln] !== 1'b1) begin
      total++; bad++;
      $display("FAIL timeout lane=%0d addr=%h actual=no_rvalid required=rvalid", ln, a);
    end
    r_o = rdata_o[ln];
    e_o = err_o[ln];
    $display("txn lane=%0d %s addr=%h wdata=%h -> rdata=%h err=%0d edges=%0d",
             ln, rd ? "LD" : "ST", a, wd, r_o, e_o, edges);
  endtask

  // ---------------- stimulus + per-cycle compare ----------------
  initial begin
    for (int ln = 0; ln < NL; ln++) begin
      req[ln] = 1'b0; rd_i[ln] = 1'b0; addr_i[ln] = 32'h0; wdata_i[ln] = 32'h0;
    end
    fork
      begin : compare_thread
        while (!done) begin
          @(negedge clk);
          for (int ln = 0; ln < NL; ln++) begin
            total++;
            if (busy_o[ln] !== (m_rem[ln] != 0) || rvalid_o[ln] !== (m_rem[ln] == 1) ||
                err_o[ln] !== (m_rem[ln] == 1 && m_err[ln]) || rdata_o[ln] !== m_rdata[ln]) begin
              bad++;
              $display("FAIL cycle lane=%0d busy=%b/%b rvalid=%b/%b err=%b/%b rdata=%h/%h (actual/required)",
                       ln, busy_o[ln], (m_rem[ln] != 0), rvalid_o[ln], (m_rem[ln] == 1),
                       err_o[ln], (m_rem[ln] == 1 && m_err[ln]), rdata_o[ln], m_rdata[ln]);
            end
          end
        end
      end
      begin : stim_thread
        logic [31:0] r;
        bit          e;
        int          ed, bc, pulses, consec, extra;
        bit          prev;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        for (int ln = 0; ln < NL; ln++) begin
          check($sformatf("reset_busy%0d", ln),   32'(busy_o[ln]),   32'h0);
          check($sformatf("reset_rvalid%0d", ln), 32'(rvalid_o[ln]), 32'h0);
          check($sformatf("reset_rdata%0d", ln),  rdata_o[ln],       32'h0);
        end
        #2 rst_n = 1'b1;

        // Fill every word with a known pattern.
        for (int ln = 0; ln < NL; ln++)
          for (int i = 0; i < DEPTH; i++)
            do_access(ln, 1'b0, BASE_T[ln] + 32'(i * 4),
                      32'hC0DE_0000 | 32'(ln << 12) | 32'(i), r, e, ed, bc);

        // Reset in the middle of a LATENCY=4 store.
        @(negedge clk);
        req[0] = 1'b1; rd_i[0] = 1'b0; addr_i[0] = 32'h10; wdata_i[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        check("midwait_busy", 32'(busy_o[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy_now",   32'(busy_o[0]),   32'h0);
        check("rst_rvalid_now", 32'(rvalid_o[0]), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_access(0, 1'b1, 32'h10, 32'h0, r, e, ed, bc);
        check("after_rst_rdata", r, 32'hDEAD_BEEF);
        check("after_rst_err",   32'(e), 32'h0);
        check("lat4_edges",      32'(ed), 32'd4);

        // Basic load latency, LATENCY=2.
        do_access(1, 1'b0, 32'h40, 32'h1234_5678, r, e, ed, bc);
        do_access(1, 1'b1, 32'h40, 32'h0, r, e, ed, bc);
        check("basic_rdata", r, 32'h1234_5678);
        check("basic_err",   32'(e), 32'h0);
        check("lat2_edges",  32'(ed), 32'd2);
        check("lat2_busy",   32'(bc), 32'd2);

        // LATENCY=1 with the request held high.
        @(negedge clk);
        req[2] = 1'b1; rd_i[2] = 1'b1; addr_i[2] = 32'h0;
        pulses = 0; consec = 0; prev = 1'b0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (rvalid_o[2] === 1'b1) begin
            pulses++;
            if (prev) consec++;
            r = rdata_o[2];
          end
          prev = (rvalid_o[2] === 1'b1);
        end
        req[2] = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd6);
        check("b2b_consec", 32'(consec), 32'd0);
        check("b2b_rdata",  r, 32'hC0DE_2000);
        $display("txn lane=2 LD-hold addr=00000000 pulses=%0d consecutive=%0d", pulses, consec);

        // Misaligned store leaves the word untouched.
        do_access(1, 1'b0, 32'h42, 32'hAAAA_5555, r, e, ed, bc);
        check("misal_err", 32'(e), 32'h1);
        do_access(1, 1'b1, 32'h40, 32'h0, r, e, ed, bc);
        check("misal_keep", r, 32'h1234_5678);
        check("misal_keep_err", 32'(e), 32'h0);

        // Out of range load / store.
        do_access(1, 1'b1, 32'h1000, 32'h0, r, e, ed, bc);
        check("oor_ld_err",   32'(e), 32'h1);
        check("oor_ld_rdata", r, 32'h0);
        do_access(1, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_0BAD, r, e, ed, bc);
        check("oor_st_err",   32'(e), 32'h1);
        for (int i = 0; i < DEPTH; i++)
          do_access(1, 1'b1, 32'(i * 4), 32'h0, r, e, ed, bc);
        check("oor_top_word", r, 32'hC0DE_13FF);

        // Store pulsed while busy must be ignored.
        @(negedge clk);
        req[1] = 1'b1; rd_i[1] = 1'b1; addr_i[1] = 32'h44;
        @(negedge clk);
        rd_i[1] = 1'b0; addr_i[1] = 32'h80; wdata_i[1] = 32'h5A5A_5A5A;
        @(negedge clk);
        req[1] = 1'b0;
        check("ign_rvalid", 32'(rvalid_o[1]), 32'h1);
        extra = 0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (rvalid_o[1] === 1'b1) extra++;
        end
        check("ign_extra", 32'(extra), 32'd0);
        do_access(1, 1'b1, 32'h80, 32'h0, r, e, ed, bc);
        check("ign_word", r, 32'hC0DE_1020);

        // Randomized traffic on every lane.
        for (int ln = 0; ln < NL; ln++) begin
          for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
              0: a = BASE_T[ln] + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(1, 3));
              1: a = (BASE_T[ln] != 0 && $urandom_range(0, 1) == 1) ?
                     BASE_T[ln] - 32'($urandom_range(1, 16) * 4) :
                     BASE_T[ln] + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
              default: a = BASE_T[ln] + 32'($urandom_range(0, 63) * 4);
            endcase
            do_access(ln, 1'($urandom), a, $urandom, r, e, ed, bc);
            check($sformatf("rand_edges%0d", ln), 32'(ed), 32'(LAT_T[ln]));
            repeat ($urandom_range(0, 2)) @(negedge clk);
          end
        end

        repeat (3) @(negedge clk);
        done = 1'b1;
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
